// File: rtl/fetch_queue_if.sv
// ROM read bus plus instruction valid/ready handshake and redirect request.
// The fetch_queue side uses the master modport; the ROM/consumer side uses slave.
interface fetch_queue_if #(
    parameter int D = 12,
    parameter int W = 9
);
    logic [D-1:0] rom_addr;
    logic         rom_rd;
    logic [W-1:0] rom_data;
    logic [W-1:0] instr;
    logic [D-1:0] instr_pc;
    logic         instr_valid;
    logic         instr_ready;
    logic         redirect;
    logic [D-1:0] redirect_target;

    modport master (
        output rom_addr, rom_rd, instr, instr_pc, instr_valid,
        input  rom_data, instr_ready, redirect, redirect_target
    );

    modport slave (
        input  rom_addr, rom_rd, instr, instr_pc, instr_valid,
        output rom_data, instr_ready, redirect, redirect_target
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC owner, 1-cycle ROM reader, prefetch FIFO and redirect squash.
// Define FETCH_PERF_EN to enable the perf_bubbles counter (tied to zero otherwise).
module fetch_queue #(
    parameter int D          = 12,
    parameter int W          = 9,
    parameter int DEPTH      = 2,
    parameter int START_ADDR = 0,
    parameter int END_ADDR   = 128
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    fetch_queue_if.master fq,
    output logic          busy,
    output logic          done,
    output logic [15:0]   perf_bubbles
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [D-1:0] START_PC = D'(START_ADDR);
    localparam logic [D-1:0] END_PC   = D'(END_ADDR);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_reg, state_next;
    logic [D-1:0]  pc_reg, pc_next;
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    logic          inflight_reg;
    logic [D-1:0]  inflight_pc_reg;

    logic [W-1:0]  code_mem [DEPTH];
    logic [D-1:0]  pc_mem   [DEPTH];

    logic          start_ok;
    logic          redirect_ok;
    logic          has_head;
    logic          pop;
    logic          push;
    logic          issue;
    logic [D-1:0]  fetch_pc;
    logic [CW:0]   occupancy;

    always_comb begin
        start_ok    = start && (state_reg != RUN);
        redirect_ok = fq.redirect && (state_reg == RUN);
        has_head    = (count_reg != '0);
        pop         = has_head && fq.instr_ready;
        // A return that coincides with a redirect belongs to the wrong path.
        push        = inflight_reg && !redirect_ok;
        // The start cycle already reads START_ADDR so the first instruction is valid two cycles later.
        fetch_pc    = start_ok ? START_PC : pc_reg;
        // A same-cycle pop frees a slot, which sustains one instruction per cycle.
        occupancy   = {1'b0, count_reg} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
        issue       = (start_ok || ((state_reg == RUN) && !redirect_ok))
                      && (fetch_pc != END_PC)
                      && (occupancy < (CW+1)'(DEPTH));

        state_next = state_reg;
        unique case (state_reg)
            IDLE, DONE: if (start) state_next = RUN;
            RUN: begin
                if ((pc_reg == END_PC) && !has_head && !inflight_reg && !redirect_ok)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase

        pc_next = pc_reg;
        if (redirect_ok)
            pc_next = fq.redirect_target;
        else if (issue)
            pc_next = fetch_pc + D'(1);
        else if (start_ok)
            pc_next = START_PC;

        count_next = count_reg;
        if (redirect_ok)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + CW'(1);
        else if (pop && !push)
            count_next = count_reg - CW'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            pc_reg          <= START_PC;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
            count_reg       <= '0;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            count_reg    <= count_next;
            inflight_reg <= issue;
            if (issue)
                inflight_pc_reg <= fetch_pc;
            if (redirect_ok) begin
                rd_ptr_reg <= '0;
                wr_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            code_mem[wr_ptr_reg] <= fq.rom_data;
            pc_mem[wr_ptr_reg]   <= inflight_pc_reg;
        end
    end

    assign fq.rom_rd      = issue;
    assign fq.rom_addr    = fetch_pc;
    assign fq.instr_valid = has_head;
    assign fq.instr       = has_head ? code_mem[rd_ptr_reg] : '0;
    assign fq.instr_pc    = has_head ? pc_mem[rd_ptr_reg] : '0;
    assign busy           = (state_reg == RUN);
    assign done           = (state_reg == DONE);

`ifdef FETCH_PERF_EN
    logic [15:0] bubbles_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            bubbles_reg <= '0;
        else if (start_ok)
            bubbles_reg <= '0;
        else if ((state_reg == RUN) && !has_head && (bubbles_reg != 16'hFFFF))
            bubbles_reg <= bubbles_reg + 16'd1;
    end

    assign perf_bubbles = bubbles_reg;
`else
    assign perf_bubbles = 16'd0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: stream-level model checked every cycle plus directed literals.
`timescale 1ns/1ps
module tb_fetch_queue;
    localparam int D          = 12;
    localparam int W          = 9;
    localparam int DEPTH      = 2;
    localparam int START_ADDR = 0;
    localparam int END_ADDR   = 128;

`ifdef FETCH_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] perf_bubbles;

    fetch_queue_if #(.D(D), .W(W)) fq ();

    fetch_queue #(
        .D(D), .W(W), .DEPTH(DEPTH), .START_ADDR(START_ADDR), .END_ADDR(END_ADDR)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .fq           (fq),
        .busy         (busy),
        .done         (done),
        .perf_bubbles (perf_bubbles)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rom_word(input logic [D-1:0] a);
        return a[W-1:0];
    endfunction

    always @(posedge clk) begin
        if (fq.rom_rd)
            fq.rom_data <= rom_word(fq.rom_addr);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: what has been fetched, what has been consumed, and where each stream goes next.
    bit           m_run      = 1'b0;
    bit           m_done     = 1'b0;
    bit           m_prev_rd  = 1'b0;
    logic [D-1:0] m_fetch    = D'(START_ADDR);
    logic [D-1:0] m_next_pc  = D'(START_ADDR);
    int           m_issued   = 0;
    int           m_accepted = 0;
    logic [15:0]  m_bubbles  = '0;
    int           accept_total = 0;
    logic [D-1:0] acc_q[$];

    bit           exp_valid, start_eff, redir_eff, pop_now, exp_rd;
    int           exp_items, outstanding;
    logic [D-1:0] fetch_addr;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_run = 1'b0; m_done = 1'b0; m_prev_rd = 1'b0;
            m_fetch = D'(START_ADDR); m_next_pc = D'(START_ADDR);
            m_issued = 0; m_accepted = 0; m_bubbles = '0;
        end else begin
            exp_items = m_issued - m_accepted - (m_prev_rd ? 1 : 0);
            exp_valid = (exp_items > 0);
            start_eff = start && !m_run;
            redir_eff = fq.redirect && m_run;
            pop_now   = exp_valid && fq.instr_ready;

            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(m_done));
            chk("instr_valid", 32'(fq.instr_valid), 32'(exp_valid));
            if (exp_valid && fq.instr_valid) begin
                chk("instr_pc", 32'(fq.instr_pc), 32'(m_next_pc));
                chk("instr", 32'(fq.instr), 32'(rom_word(m_next_pc)));
            end
            chk("perf_bubbles", 32'(perf_bubbles), PERF_ON ? 32'(m_bubbles) : 32'd0);

            fetch_addr  = start_eff ? D'(START_ADDR) : m_fetch;
            outstanding = start_eff ? 0 : (m_issued - m_accepted - (pop_now ? 1 : 0));
            exp_rd = (start_eff || (m_run && !redir_eff))
                     && (fetch_addr != D'(END_ADDR)) && (outstanding < DEPTH);
            chk("rom_rd", 32'(fq.rom_rd), 32'(exp_rd));
            if (exp_rd && fq.rom_rd)
                chk("rom_addr", 32'(fq.rom_addr), 32'(fetch_addr));

            if (start_eff) begin
                m_run = 1'b1; m_done = 1'b0; m_bubbles = '0;
                m_accepted = 0;
                m_issued   = exp_rd ? 1 : 0;
                m_fetch    = fetch_addr + D'(exp_rd ? 1 : 0);
                m_next_pc  = D'(START_ADDR);
                m_prev_rd  = exp_rd;
            end else if (m_run) begin
                if (!exp_valid && m_bubbles != 16'hFFFF)
                    m_bubbles = m_bubbles + 16'd1;
                if (pop_now) begin
                    acc_q.push_back(m_next_pc);
                    accept_total++;
                    $display("ACCEPT pc=%0d instr=%0d", fq.instr_pc, fq.instr);
                    m_next_pc = m_next_pc + D'(1);
                end
                if (redir_eff) begin
                    m_fetch = fq.redirect_target; m_next_pc = fq.redirect_target;
                    m_issued = 0; m_accepted = 0; m_prev_rd = 1'b0;
                end else if (m_fetch == D'(END_ADDR) && m_issued == m_accepted) begin
                    m_run = 1'b0; m_done = 1'b1; m_prev_rd = 1'b0;
                end else begin
                    if (exp_rd) begin
                        m_issued++;
                        m_fetch = m_fetch + D'(1);
                    end
                    if (pop_now)
                        m_accepted++;
                    m_prev_rd = exp_rd;
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name, input int limit);
        int n = 0;
        while (!done && n < limit) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    task automatic wait_valid(input string name, input int limit);
        int n = 0;
        while (!fq.instr_valid && n < limit) begin
            cyc(1);
            n++;
        end
        chk(name, 32'(fq.instr_valid), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_valid"}, 32'(fq.instr_valid), 32'd0);
        chk({tag, "_rom_rd"}, 32'(fq.rom_rd), 32'd0);
        chk({tag, "_instr"}, 32'(fq.instr), 32'd0);
        chk({tag, "_instr_pc"}, 32'(fq.instr_pc), 32'd0);
        chk({tag, "_perf"}, 32'(perf_bubbles), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    logic [D-1:0] head_pc;
    int           n_before;

    initial begin
        rst_n = 1'b1; start = 1'b0;
        fq.instr_ready = 1'b0; fq.redirect = 1'b0; fq.redirect_target = '0;
        #2 rst_n = 1'b0;
        #2 chk_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(2);

        // Full program with the consumer always ready.
        acc_q.delete(); accept_total = 0;
        fq.instr_ready = 1'b1; start = 1'b1;
        cyc(1); start = 1'b0;
        chk("startup_c1_valid", 32'(fq.instr_valid), 32'd0);
        chk("startup_c1_addr", 32'(fq.rom_addr), 32'd1);
        cyc(1);
        chk("first_valid", 32'(fq.instr_valid), 32'd1);
        chk("first_pc", 32'(fq.instr_pc), 32'd0);
        wait_done("run1_done_timeout", 400);
        chk("run1_accepts", 32'(accept_total), 32'd128);
        chk("run1_last_pc", 32'(acc_q[acc_q.size()-1]), 32'd127);
        chk("run1_busy_after", 32'(busy), 32'd0);

        // Backpressure: consumer stalls for ten cycles after start.
        acc_q.delete();
        fq.instr_ready = 1'b0; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(9);
        chk("hold_rom_rd", 32'(fq.rom_rd), 32'd0);
        chk("hold_valid", 32'(fq.instr_valid), 32'd1);
        chk("hold_pc", 32'(fq.instr_pc), 32'd0);
        chk("hold_accepts", 32'(acc_q.size()), 32'd0);
        fq.instr_ready = 1'b1;
        cyc(6);
        chk("release_count", 32'(acc_q.size()), 32'd6);
        chk("release_first", 32'(acc_q[0]), 32'd0);
        chk("release_last", 32'(acc_q[5]), 32'd5);

        // Redirect while the queue is full with a read returning.
        n_before = acc_q.size();
        fq.instr_ready = 1'b0; fq.redirect = 1'b1; fq.redirect_target = D'(40);
        cyc(1);
        fq.redirect = 1'b0; fq.instr_ready = 1'b1;
        wait_valid("redir40_timeout", 6);
        chk("redir40_pc", 32'(fq.instr_pc), 32'd40);
        chk("redir40_instr", 32'(fq.instr), 32'd40);
        chk("redir40_no_stale", 32'(acc_q.size()), 32'(n_before));

        // Redirect with a same-cycle pop, into the top of the address space to exercise wrap.
        cyc(3);
        head_pc = fq.instr_pc;
        acc_q.delete();
        fq.redirect = 1'b1; fq.redirect_target = D'(4094);
        cyc(1);
        fq.redirect = 1'b0;
        cyc(5);
        chk("wrap_count_ok", 32'(acc_q.size() >= 4), 32'd1);
        if (acc_q.size() >= 4) begin
            chk("redir_pop_head", 32'(acc_q[0]), 32'(head_pc));
            chk("wrap_pc0", 32'(acc_q[1]), 32'd4094);
            chk("wrap_pc1", 32'(acc_q[2]), 32'd4095);
            chk("wrap_pc2", 32'(acc_q[3]), 32'd0);
        end

        // Redirect straight to END_ADDR drains to DONE.
        fq.redirect = 1'b1; fq.redirect_target = D'(END_ADDR);
        cyc(1);
        fq.redirect = 1'b0;
        chk("redir_end_busy", 32'(busy), 32'd1);
        cyc(1);
        chk("redir_end_done", 32'(done), 32'd1);
        chk("redir_end_busy_after", 32'(busy), 32'd0);

        // Bubble count: one startup bubble plus two after a redirect.
        accept_total = 0;
        fq.instr_ready = 1'b1; start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(5);
        fq.redirect = 1'b1; fq.redirect_target = D'(40);
        cyc(1);
        fq.redirect = 1'b0;
        cyc(6);
        chk("perf_literal", 32'(perf_bubbles), PERF_ON ? 32'd3 : 32'd0);
        wait_done("run3_done_timeout", 200);
        chk("run3_accepts", 32'(accept_total), 32'd93);

        // Reset in the middle of a run.
        start = 1'b1;
        cyc(1); start = 1'b0;
        cyc(4);
        rst_n = 1'b0;
        #1 chk_reset_outputs("midreset");
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_valid", 32'(fq.instr_valid), 32'd0);
        chk("post_reset_rom_rd", 32'(fq.rom_rd), 32'd0);
        chk("post_reset_done", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
